// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   FIELD_W     : width of the minutes and seconds fields
//   MAX_VAL_DEF : default terminal value of both fields
//   state_t     : controller states
package stopwatch_pkg;

    localparam int FIELD_W     = 6;
    localparam int MAX_VAL_DEF = 59;

    typedef enum logic [1:0] {
        PAUSE  = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo (MAX_VAL+1) counter for one stopwatch field.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, value -> 0
//   inc   : advance by one, wrapping MAX_VAL to 0
//   clr   : zero the field; wins over inc
//   value : registered field value
//   carry : combinational, high when inc is applied at MAX_VAL
module mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [FIELD_W-1:0] value,
    output logic               carry
);

    localparam logic [FIELD_W-1:0] TERM = FIELD_W'(MAX_VAL);

    logic [FIELD_W-1:0] value_q;
    logic [FIELD_W-1:0] value_d;
    logic               at_term;

    assign at_term = (value_q == TERM);
    assign carry   = inc && at_term;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = at_term ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: mm:ss counting, pause/resume, per-field adjust
// with blinking of the field being adjusted.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   PAUSE  | fields hold, ticks ignored
//   RUN    | tick_1hz advances seconds, carry into minutes
//   ADJUST | tick_2hz advances the field picked by sw_sel, no carry
//
// Ports:
//   clk_100MHz  : master clock
//   rst         : synchronous active-high reset
//   tick_1hz    : count enable (RUN)
//   tick_2hz    : adjust increment enable (ADJUST)
//   tick_blink  : blink phase toggle enable
//   pause_pulse : pause/resume request
//   clr_pulse   : zero both fields, any state
//   sw_adj      : level, high forces ADJUST
//   sw_sel      : level, 0 = minutes, 1 = seconds while adjusting
//   minutes     : minutes field
//   seconds     : seconds field
//   blank_min   : blank the minutes digits
//   blank_sec   : blank the seconds digits
//   running     : high in RUN
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic               clk_100MHz,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               tick_blink,
    input  logic               pause_pulse,
    input  logic               clr_pulse,
    input  logic               sw_adj,
    input  logic               sw_sel,
    output logic [FIELD_W-1:0] minutes,
    output logic [FIELD_W-1:0] seconds,
    output logic               blank_min,
    output logic               blank_sec,
    output logic               running
);

    state_t state_q, state_d;
    logic   blink_q, blink_d;
    logic   blank_min_q, blank_min_d;
    logic   blank_sec_q, blank_sec_d;
    logic   running_q, running_d;

    logic   sec_inc, min_inc, sec_carry, min_carry;
    logic   run_tick, adj_tick;

    // Counting is qualified by the current state, so a tick that coincides
    // with a state change is applied under the old state.
    assign run_tick = (state_q == RUN) && tick_1hz;
    assign adj_tick = (state_q == ADJUST) && tick_2hz;

    assign sec_inc  = run_tick || (adj_tick && sw_sel);
    assign min_inc  = (run_tick && sec_carry) || (adj_tick && !sw_sel);

    mod_counter #(.MAX_VAL(MAX_VAL)) u_sec (
        .clk   (clk_100MHz),
        .rst   (rst),
        .inc   (sec_inc),
        .clr   (clr_pulse),
        .value (seconds),
        .carry (sec_carry)
    );

    // Minute carry is dropped: 59:59 rolls over to 00:00.
    mod_counter #(.MAX_VAL(MAX_VAL)) u_min (
        .clk   (clk_100MHz),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (clr_pulse),
        .value (minutes),
        .carry (min_carry)
    );

    always_comb begin
        state_d = state_q;
        if (sw_adj) begin
            state_d = ADJUST;
        end else begin
            unique case (state_q)
                PAUSE:   if (pause_pulse) state_d = RUN;
                RUN:     if (pause_pulse) state_d = PAUSE;
                ADJUST:  state_d = PAUSE;
                default: state_d = PAUSE;
            endcase
        end
    end

    always_comb begin
        blink_d = blink_q;
        if ((state_d == ADJUST) && (state_q != ADJUST)) begin
            blink_d = 1'b0;
        end else if (tick_blink) begin
            blink_d = ~blink_q;
        end
    end

    // Outputs are registered from next-state values so they line up with
    // state_q and the field registers on the same edge.
    always_comb begin
        running_d   = (state_d == RUN);
        blank_min_d = (state_d == ADJUST) && !sw_sel && blink_d;
        blank_sec_d = (state_d == ADJUST) &&  sw_sel && blink_d;
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q     <= PAUSE;
            blink_q     <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_q     <= blink_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
            running_q   <= running_d;
        end
    end

    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;
    assign running   = running_q;

    logic unused_carry;
    assign unused_carry = min_carry;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_blink = 1'b0;
    logic       pause_pulse = 1'b0, clr_pulse = 1'b0;
    logic       sw_adj = 1'b0, sw_sel = 1'b0;
    logic [5:0] minutes, seconds;
    logic       blank_min, blank_sec, running;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic [5:0] mm;
        logic [5:0] ss;
        logic       run;
        logic       bm;
        logic       bs;
    } exp_t;

    exp_t sb[$];

    stopwatch_ctrl #(.MAX_VAL(59)) dut (
        .clk_100MHz  (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .tick_blink  (tick_blink),
        .pause_pulse (pause_pulse),
        .clr_pulse   (clr_pulse),
        .sw_adj      (sw_adj),
        .sw_sel      (sw_sel),
        .minutes     (minutes),
        .seconds     (seconds),
        .blank_min   (blank_min),
        .blank_sec   (blank_sec),
        .running     (running)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive pulses at negedge, queue the expected result,
    // then compare the registered outputs just after the rising edge.
    task automatic step(input bit r, input bit pp, input bit cp, input bit t1,
                        input bit t2, input bit tk, input string tag,
                        input logic [5:0] emm, input logic [5:0] ess,
                        input logic erun, input logic ebm, input logic ebs);
        exp_t e;
        logic [14:0] obs, want;
        @(negedge clk);
        rst = r; pause_pulse = pp; clr_pulse = cp;
        tick_1hz = t1; tick_2hz = t2; tick_blink = tk;
        sb.push_back('{tag, emm, ess, erun, ebm, ebs});
        @(posedge clk);
        #1;
        rst = 1'b0; pause_pulse = 1'b0; clr_pulse = 1'b0;
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e    = sb.pop_front();
            obs  = {minutes, seconds, running, blank_min, blank_sec};
            want = {e.mm, e.ss, e.run, e.bm, e.bs};
            assert (obs === want) else begin
                fails++;
                $error("FAIL %s: observed mm=%0d ss=%0d run=%b bm=%b bs=%b expected mm=%0d ss=%0d run=%b bm=%b bs=%b",
                       e.tag, minutes, seconds, running, blank_min, blank_sec,
                       e.mm, e.ss, e.run, e.bm, e.bs);
            end
        end
    endtask

    initial begin
        // reset and basic run
        step(1,0,0,0,0,0, "reset", 0, 0, 0, 0, 0);
        step(0,1,0,0,0,0, "start", 0, 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++)
            step(0,0,0,1,0,0, "run_tick", 0, 6'(i), 1, 0, 0);
        step(0,1,0,0,0,0, "pause", 0, 3, 0, 0, 0);
        step(0,0,0,1,1,0, "pause_hold", 0, 3, 0, 0, 0);
        step(0,0,1,0,0,0, "clr_pause", 0, 0, 0, 0, 0);

        // preload 00:59 via adjust, then run across the minute
        sw_adj = 1'b1; sw_sel = 1'b1;
        step(0,0,0,0,0,0, "enter_adj", 0, 0, 0, 0, 0);
        for (int i = 1; i <= 59; i++)
            step(0,0,0,0,1,0, "adj_sec", 0, 6'(i), 0, 0, 0);
        sw_adj = 1'b0;
        step(0,0,0,0,0,0, "exit_adj", 0, 59, 0, 0, 0);
        step(0,1,0,0,0,0, "start2", 0, 59, 1, 0, 0);
        step(0,0,0,1,0,0, "sec_wrap", 1, 0, 1, 0, 0);

        // preload 59:59, then full rollover
        step(0,1,0,0,0,0, "pause2", 1, 0, 0, 0, 0);
        sw_adj = 1'b1; sw_sel = 1'b0;
        step(0,0,0,0,0,0, "enter_adj2", 1, 0, 0, 0, 0);
        for (int i = 2; i <= 59; i++)
            step(0,0,0,0,1,0, "adj_min", 6'(i), 0, 0, 0, 0);
        sw_sel = 1'b1;
        for (int i = 1; i <= 59; i++)
            step(0,0,0,0,1,0, "adj_sec2", 59, 6'(i), 0, 0, 0);
        sw_adj = 1'b0;
        step(0,1,0,0,0,0, "exit_adj_pp", 59, 59, 0, 0, 0);
        step(0,1,0,0,0,0, "start3", 59, 59, 1, 0, 0);
        step(0,0,0,1,0,0, "full_wrap", 0, 0, 1, 0, 0);

        // adjust seconds across its wrap, no carry, tick_1hz ignored
        sw_adj = 1'b1; sw_sel = 1'b1;
        step(0,0,0,0,0,0, "enter_adj3", 0, 0, 0, 0, 0);
        for (int i = 1; i <= 58; i++)
            step(0,0,0,0,1,0, "adj_to58", 0, 6'(i), 0, 0, 0);
        step(0,0,0,0,1,0, "adj_59", 0, 59, 0, 0, 0);
        step(0,0,0,0,1,0, "adj_wrap", 0, 0, 0, 0, 0);
        step(0,0,0,0,1,0, "adj_01", 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0,0,0,1,0,0, "adj_ign1hz", 0, 1, 0, 0, 0);

        // blink: phase cleared on ADJUST entry, toggles, survives sw_sel change
        sw_adj = 1'b0;
        step(0,0,0,0,0,0, "exit_adj3", 0, 1, 0, 0, 0);
        step(0,0,0,0,0,1, "blink_pause", 0, 1, 0, 0, 0);
        sw_adj = 1'b1; sw_sel = 1'b0;
        step(0,0,0,0,0,0, "blink_entry_clr", 0, 1, 0, 0, 0);
        step(0,0,0,0,0,1, "blink_on", 0, 1, 0, 1, 0);
        step(0,0,0,0,0,1, "blink_off", 0, 1, 0, 0, 0);
        step(0,0,0,0,0,1, "blink_on2", 0, 1, 0, 1, 0);
        sw_sel = 1'b1;
        step(0,0,0,0,0,0, "sel_keep_phase", 0, 1, 0, 0, 1);
        sw_adj = 1'b0;
        step(0,0,0,0,0,0, "exit_blank", 0, 1, 0, 0, 0);

        // sw_adj beats pause_pulse; pause_pulse ignored in ADJUST
        sw_adj = 1'b1;
        step(0,1,0,0,0,0, "adj_over_pp", 0, 1, 0, 0, 0);
        step(0,1,0,0,0,0, "pp_in_adj", 0, 1, 0, 0, 0);
        sw_adj = 1'b0;
        step(0,0,0,0,0,0, "adj_to_pause", 0, 1, 0, 0, 0);

        // preload 12:34, clear and pause coincident with tick_1hz
        step(0,0,1,0,0,0, "clr", 0, 0, 0, 0, 0);
        sw_adj = 1'b1; sw_sel = 1'b0;
        step(0,0,0,0,0,0, "enter_adj4", 0, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++)
            step(0,0,0,0,1,0, "adj_min12", 6'(i), 0, 0, 0, 0);
        sw_sel = 1'b1;
        for (int i = 1; i <= 34; i++)
            step(0,0,0,0,1,0, "adj_sec34", 12, 6'(i), 0, 0, 0);
        sw_adj = 1'b0;
        step(0,0,0,0,0,0, "exit_adj4", 12, 34, 0, 0, 0);
        step(0,1,0,0,0,0, "start4", 12, 34, 1, 0, 0);
        step(0,0,1,1,0,0, "clr_over_tick", 0, 0, 1, 0, 0);
        step(0,1,0,1,0,0, "pause_with_tick", 0, 1, 0, 0, 0);

        // reset in ADJUST at 07:07 with seconds blanked
        step(0,0,1,0,0,0, "clr2", 0, 0, 0, 0, 0);
        sw_adj = 1'b1; sw_sel = 1'b0;
        step(0,0,0,0,0,0, "enter_adj5", 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++)
            step(0,0,0,0,1,0, "adj_min7", 6'(i), 0, 0, 0, 0);
        sw_sel = 1'b1;
        for (int i = 1; i <= 7; i++)
            step(0,0,0,0,1,0, "adj_sec7", 7, 6'(i), 0, 0, 0);
        step(0,0,0,0,0,1, "blank_sec_on", 7, 7, 0, 0, 1);
        step(1,1,0,1,1,1, "rst_in_adj", 0, 0, 0, 0, 0);
        sw_adj = 1'b0;
        step(0,0,0,0,0,0, "post_rst", 0, 0, 0, 0, 0);
        step(0,1,0,0,0,0, "post_rst_run", 0, 0, 1, 0, 0);
        step(0,0,0,1,0,0, "run_tick2", 0, 1, 1, 0, 0);
        step(1,0,0,1,0,0, "rst_in_run", 0, 0, 0, 0, 0);
        step(0,0,0,1,0,0, "rst_left_pause", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
